// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial add/subtract sequencer driving an external 1-bit
//               full-adder cell. Operands are taken in through a valid/ready
//               handshake. One bit pair is presented per cycle, LSB first.
//               The sum and its flags (carry, zero, signed overflow) are
//               returned through a second valid/ready handshake.
//               Optional feature macro: SERIAL_SUB_EN (op=1 gives A-B).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Only WIDTH-1 sum bits need storing: the last bit arrives from the cell
    // on the MSB step and is merged directly into the result.
    logic [WIDTH-2:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_q;
    logic             r_cout;
    logic             r_zero;
    logic             r_ovf;
    logic             r_out_valid;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_init;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

`ifdef SERIAL_SUB_EN
    // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
    assign w_b_load   = op ? ~b : b;
    assign w_cin_init = op;
`else
    // Addition only; op has no effect in this build.
    assign w_b_load   = b;
    assign w_cin_init = 1'b0;
    logic w_unused_op;
    assign w_unused_op = op;
`endif

    // Sum bits assembled so far plus the bit the cell is returning this cycle.
    assign w_sum_next = {fa_s, r_sum_sh};
    assign w_last     = (r_count == CW'(WIDTH - 1));

    // Cell drive and handshake outputs come straight from registered state.
    assign in_ready  = (r_state == ST_IDLE);
    assign fa_a      = (r_state == ST_RUN) ? r_a_sh[0] : 1'b0;
    assign fa_b      = (r_state == ST_RUN) ? r_b_sh[0] : 1'b0;
    assign fa_cin    = (r_state == ST_RUN) ? r_carry_q : 1'b0;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

    // Sequencer: load operands, step one bit per cycle, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_sum       <= '0;
            r_carry_q   <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh    <= a;
                        r_b_sh    <= w_b_load;
                        r_carry_q <= w_cin_init;
                        r_count   <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum_sh  <= w_sum_next[WIDTH-1:1];
                    r_carry_q <= fa_co;
                    r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_count   <= r_count + 1'b1;
                    if (w_last) begin
                        r_sum       <= w_sum_next;
                        r_cout      <= fa_co;
                        // Carry into the MSB differing from carry out of it.
                        r_ovf       <= r_carry_q ^ fa_co;
                        r_zero      <= (w_sum_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_seq
// Description : Self-checking bench for serial_add_seq. Models the external
//               full-adder cell and compares each result with an integer
//               arithmetic reference. Honors SERIAL_SUB_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int MOD   = 1 << WIDTH;
`ifdef SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_co;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_seq #(.WIDTH(WIDTH), .CW(CW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_s      (fa_s),
        .fa_co     (fa_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    // External 1-bit full-adder cell
    assign {fa_co, fa_s} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic
    function automatic void model(input int x, input int y, input bit o,
                                  output int s, output bit c, output bit z, output bit v);
        int sx, sy, r;
        bit eo;
        eo = o & SUB_EN;
        sx = (x >= MOD / 2) ? x - MOD : x;
        sy = (y >= MOD / 2) ? y - MOD : y;
        if (eo) begin
            s = (x - y + MOD) % MOD;
            c = (x >= y);
            r = sx - sy;
        end else begin
            s = (x + y) % MOD;
            c = ((x + y) >= MOD);
            r = sx + sy;
        end
        z = (s == 0);
        v = (r > MOD / 2 - 1) || (r < -(MOD / 2));
    endfunction

    // Runs one operation. Entered and left at a negedge with the DUT idle.
    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic o, input int hold);
        logic [31:0] fa_seq;
        int          cyc;
        bit          done;
        int          es;
        bit          ec, ez, ev;
        fa_seq = '0;
        cyc    = 0;
        done   = 1'b0;
        model(int'(x), int'(y), o, es, ec, ez, ev);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        op       = o;
        @(posedge clk);
        while (!done && cyc < 20) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            op       = 1'($urandom_range(0, 1));
            if (out_valid) done = 1'b1;
            else begin
                fa_seq[cyc] = fa_a;
                cyc++;
            end
        end
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(cyc), 32'(WIDTH));
        check("fa_a_seq", fa_seq, 32'(x));
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("zero", 32'(zero), 32'(ez));
        check("ovf", 32'(ovf), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(i & 1);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_flags", {29'd0, cout, zero, ovf}, {29'd0, ec, ez, ev});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Abort an operation at count==4 with an asynchronous reset
    task automatic reset_mid_run();
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h33;
        op       = 1'b0;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", {29'd0, cout, zero, ovf}, 32'd0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", {29'd0, cout, zero, ovf}, 32'd0);
        check("reset_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h35, 8'h4A, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 2);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 5);
        run_op(8'h10, 8'h20, 1'b1, 1);
        run_op(8'h80, 8'h01, 1'b1, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        reset_mid_run();
        run_op(8'h01, 8'h02, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial sequencer that feeds the team's 1-bit full-adder cell (inputs a, b, cin; outputs s, co), which is instantiated outside this block.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Each cycle it presents one operand bit pair, LSB first, plus the registered carry to the cell, and shifts the returned sum bit into a result register.
- After WIDTH cycles it presents the sum and flags (carry, zero, signed overflow) through a valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CW, 4, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  1  0=add, 1=sub (only with SERIAL_SUB_EN)
- fa_a  out  1  bit to full-adder cell input a
- fa_b  out  1  bit to full-adder cell input b
- fa_cin  out  1  carry to full-adder cell input cin
- fa_s  in  1  sum bit from cell (combinational)
- fa_co  in  1  carry out from cell (combinational)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  final carry out
- zero  out  1  sum == 0
- ovf  out  1  two's-complement overflow

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE; operand shift regs, sum, cout, zero, ovf, carry_q and count all 0; out_valid=0.
  - In-flight operation is discarded; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; out_valid=0.
  - On in_valid at a clock edge:
    - a_sh<=a; b_sh<=b (or ~b when subtracting); carry_q<=0 (or 1 when subtracting); count<=0.
    - Go to RUN.
- RUN:
  - in_ready=0. in_valid is ignored.
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q (driven combinationally from registers).
  - Each edge:
    - sum_sh<={fa_s, sum_sh[WIDTH-1:1]}; carry_q<=fa_co.
    - a_sh and b_sh shift right by 1.
    - count<=count+1.
  - On the edge where count==WIDTH-1 (MSB step):
    - sum<=final sum_sh value, including this fa_s.
    - cout<=fa_co.
    - ovf<=carry_q^fa_co (carry into MSB xor carry out of MSB).
    - zero<=(final sum==0).
    - Go to DONE.
- Outside RUN: fa_a, fa_b and fa_cin are 0.
- DONE:
  - out_valid=1. sum and flags are held stable until the handshake.
  - On out_valid&&out_ready at an edge: go to IDLE.
  - No output bypass: new operands are accepted only from IDLE, the cycle after the handshake.
- Latency:
  - Operands accepted at edge 0 give out_valid=1 after edge WIDTH.
  - Throughput is one operation per WIDTH+2 cycles when out_ready=1.
- Arithmetic is modulo 2^WIDTH; cout and ovf report the wrap.
- Flags (sum, cout, zero, ovf) keep their last values through IDLE and RUN. They are meaningful only while out_valid=1.

Optional Feature:
- Macro SERIAL_SUB_EN.
- Defined:
  - If op=1 at acceptance, b is inverted on load and carry_q is initialised to 1, giving A−B.
  - cout=1 means no borrow. ovf indicates signed subtraction overflow.
  - op is sampled only at acceptance.
- Undefined:
  - op is ignored; every operation is addition with carry_q initialised to 0.
  - No inverter logic is generated.

Test Plan:
- 0x35+0x4A, out_ready=1 -> out_valid rises exactly 8 cycles after acceptance; sum=0x7F, cout=0, zero=0, ovf=0; fa_a sequence LSB-first matches 0x35.
- 0xFF+0x01 -> sum=0x00, cout=1, zero=1, ovf=0.
- 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; then 0x80+0x80 -> sum=0x00, cout=1, zero=1, ovf=1.
- SERIAL_SUB_EN defined, op=1: 0x10−0x20 -> sum=0xF0, cout=0, ovf=0; 0x80−0x01 -> sum=0x7F, cout=1, ovf=1. Macro undefined with op=1 -> 0x10+0x20 gives sum=0x30.
- out_ready held low 5 cycles in DONE -> sum/flags stable, in_ready=0, in_valid pulses ignored; handshake -> IDLE next cycle, then new operands accepted.
- rst_n pulsed low asynchronously at RUN count=4 -> all outputs 0 immediately, state IDLE, in_ready=1 after release; next op 0x01+0x02 -> sum=0x03 correctly.
